// File: rtl/egress_frame_reader.sv
// ============================================================================
// Module      : egress_frame_reader
// Description : Pops per-frame descriptors (length, drop verdict) and reads
//               the matching words from the shared frame data FIFO.
//               Forwarded frames leave on an AXI-stream port through a
//               2-entry skid buffer; dropped frames are flushed silently.
// Ports       : clk/reset        - clock, synchronous active-high reset
//               desc_*           - show-ahead descriptor FIFO read side
//               data_*           - show-ahead frame data FIFO read side
//               egress_*         - AXI-stream master (registered outputs)
//               frame_sent/frame_dropped/len_error - 1-cycle event pulses
//               sent_count/drop_count              - wrapping statistics
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module egress_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 11,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  desc_empty,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic                  desc_drop,
    output logic                  desc_rd,
    input  logic                  data_empty,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_rd,
    output logic                  egress_tvalid,
    output logic [DATA_WIDTH-1:0] egress_tdata,
    output logic                  egress_tlast,
    input  logic                  egress_tready,
    output logic                  frame_sent,
    output logic                  frame_dropped,
    output logic                  len_error,
    output logic [CNT_WIDTH-1:0]  sent_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [1:0]           c_idle    = 2'd0;
    localparam logic [1:0]           c_stream  = 2'd1;
    localparam logic [1:0]           c_flush   = 2'd2;
    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [1:0]            r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0]  r_rem, w_rem_nxt;
    logic                  w_take_desc, w_desc_rd, w_data_rd;
    logic                  w_push, w_push_last, w_flush_done, w_len_zero;

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head_data, r_tail_data;
    logic                  r_head_last, r_tail_last;
    logic                  w_deq, w_free;

    logic                  r_frame_sent, r_frame_dropped, r_len_error;
    logic [CNT_WIDTH-1:0]  r_sent_count, r_drop_count;

    assign w_deq      = (r_count != 2'd0) && egress_tready;
    // A slot counts as free if the head leaves this same cycle.
    assign w_free     = (r_count != 2'd2) || w_deq;
    assign w_len_zero = (desc_len == '0);

    // ------------------------------------------------------------------
    // Next-state / FIFO read control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_take_desc  = 1'b0;
        w_desc_rd    = 1'b0;
        w_data_rd    = 1'b0;
        w_push       = 1'b0;
        w_push_last  = 1'b0;
        w_flush_done = 1'b0;

        case (r_state)
            c_idle: begin
                if (!desc_empty) w_take_desc = 1'b1;
            end
            c_stream: begin
                if (!data_empty && w_free) begin
                    w_data_rd   = 1'b1;
                    w_push      = 1'b1;
                    w_push_last = (r_rem == c_len_one);
                    w_rem_nxt   = r_rem - c_len_one;
                    if (r_rem == c_len_one) begin
                        w_state_nxt = c_idle;
                        // Fetch the next descriptor together with the last
                        // pop so consecutive frames stream without a gap.
                        if (!desc_empty) w_take_desc = 1'b1;
                    end
                end
            end
            c_flush: begin
                if (!data_empty) begin
                    w_data_rd = 1'b1;
                    w_rem_nxt = r_rem - c_len_one;
                    if (r_rem == c_len_one) begin
                        w_flush_done = 1'b1;
                        w_state_nxt  = c_idle;
                    end
                end
            end
            default: w_state_nxt = c_idle;
        endcase

        if (w_take_desc) begin
            w_desc_rd = 1'b1;
            w_rem_nxt = desc_len;
            if (w_len_zero)     w_state_nxt = c_idle;
            else if (desc_drop) w_state_nxt = c_flush;
            else                w_state_nxt = c_stream;
        end

        if (reset) begin
            w_desc_rd = 1'b0;
            w_data_rd = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid buffer: head drives egress, tail absorbs a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
        end else begin
            case ({w_push, w_deq})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_data <= data_rdata;
                        r_head_last <= w_push_last;
                    end else begin
                        r_tail_data <= data_rdata;
                        r_tail_last <= w_push_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_count     <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head_data <= data_rdata;
                        r_head_last <= w_push_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= data_rdata;
                        r_tail_last <= w_push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event pulses and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_sent    <= 1'b0;
            r_frame_dropped <= 1'b0;
            r_len_error     <= 1'b0;
            r_sent_count    <= '0;
            r_drop_count    <= '0;
        end else begin
            r_frame_sent    <= w_deq && r_head_last;
            r_frame_dropped <= w_flush_done;
            r_len_error     <= w_desc_rd && w_len_zero;
            if (w_deq && r_head_last) r_sent_count <= r_sent_count + c_cnt_one;
            if (w_flush_done)         r_drop_count <= r_drop_count + c_cnt_one;
        end
    end

    assign desc_rd       = w_desc_rd;
    assign data_rd       = w_data_rd;
    assign egress_tvalid = (r_count != 2'd0);
    assign egress_tdata  = r_head_data;
    assign egress_tlast  = r_head_last;
    assign frame_sent    = r_frame_sent;
    assign frame_dropped = r_frame_dropped;
    assign len_error     = r_len_error;
    assign sent_count    = r_sent_count;
    assign drop_count    = r_drop_count;

endmodule

`default_nettype wire
